// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 pooling read scheduler.
package pool_pkg;

  localparam int unsigned WIN_SIZE  = 2;
  localparam int unsigned WIN_ELEMS = WIN_SIZE * WIN_SIZE;
  localparam int unsigned ELEM_W    = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ISSUE,
    GAP,
    DONE
  } pool_sched_state_t;

  // Offset of element 0..3 inside a window: bit 1 selects the lower row.
  function automatic int unsigned elem_offset(input logic [ELEM_W-1:0] elem,
                                              input int unsigned       map_w);
    return (elem[1] ? map_w : 32'd0) + {31'd0, elem[0]};
  endfunction

endpackage

// File: rtl/pool_sched_if.sv
// Control and source-RAM read port of the pooling scheduler.
interface pool_sched_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned WIN_W      = 4
);
  logic                  go;
  logic                  abort;
  logic                  pool_bsy;
  logic                  src_rd_en;
  logic [ADDR_WIDTH-1:0] src_rd_addr;
  logic                  pool_strt;
  logic [WIN_W-1:0]      win_cnt;
  logic                  busy;
  logic                  done;

  modport master (
    input  go, abort, pool_bsy,
    output src_rd_en, src_rd_addr, pool_strt, win_cnt, busy, done
  );

  modport slave (
    output go, abort, pool_bsy,
    input  src_rd_en, src_rd_addr, pool_strt, win_cnt, busy, done
  );
endinterface

// File: rtl/pool_addr_gen.sv
// Window base tracking (column/row pair counters) and registered element address.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int unsigned MAP_W      = 8,
  parameter int unsigned MAP_H      = 8,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  adv,
  input  logic                  issue_d,
  input  logic [ELEM_W-1:0]     elem_d,
  output logic                  last_win_c,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int unsigned CP_N = MAP_W / WIN_SIZE;
  localparam int unsigned RP_N = MAP_H / WIN_SIZE;
  localparam int unsigned CP_W = (CP_N > 1) ? $clog2(CP_N) : 1;
  localparam int unsigned RP_W = (RP_N > 1) ? $clog2(RP_N) : 1;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CP_W-1:0]       cp_q, cp_d;
  logic [RP_W-1:0]       rp_q, rp_d;
  logic                  last_col_c;
  logic                  last_row_c;

  assign last_col_c = (cp_q == CP_W'(CP_N - 1));
  assign last_row_c = (rp_q == RP_W'(RP_N - 1));
  assign last_win_c = last_col_c && last_row_c;
  assign addr       = addr_q;

  // Incremental base: +2 along a row pair, +MAP_W+2 to jump to the next row pair.
  always_comb begin
    base_d = base_q;
    cp_d   = cp_q;
    rp_d   = rp_q;
    addr_d = '0;
    if (clr) begin
      base_d = '0;
      cp_d   = '0;
      rp_d   = '0;
    end else if (adv) begin
      if (last_col_c) begin
        cp_d   = '0;
        rp_d   = rp_q + RP_W'(1);
        base_d = base_q + ADDR_WIDTH'(MAP_W + 2);
      end else begin
        cp_d   = cp_q + CP_W'(1);
        base_d = base_q + ADDR_WIDTH'(2);
      end
    end
    if (issue_d) begin
      addr_d = base_d + ADDR_WIDTH'(elem_offset(elem_d, MAP_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      cp_q   <= '0;
      rp_q   <= '0;
      addr_q <= '0;
    end else begin
      base_q <= base_d;
      cp_q   <= cp_d;
      rp_q   <= rp_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/pool_sched.sv
// Frame scheduler: walks 2x2 pooling windows over a feature map and issues
// four source-RAM reads per window, honouring pool unit back-pressure between windows.
module pool_sched
  import pool_pkg::*;
#(
  parameter int unsigned MAP_W      = 8,
  parameter int unsigned MAP_H      = 8,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst,
  pool_sched_if.master bus
);

  localparam int unsigned NWIN  = (MAP_W * MAP_H) / WIN_ELEMS;
  localparam int unsigned WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

  pool_sched_state_t     state_q, state_d;
  logic [ELEM_W-1:0]     elem_q, elem_d;
  logic [WIN_W-1:0]      win_q, win_d;
  logic                  adv_c;
  logic                  clr_c;
  logic                  last_win_c;
  logic                  rd_en_q, rd_en_d;
  logic                  strt_q, strt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] rd_addr;

  pool_addr_gen #(
    .MAP_W      (MAP_W),
    .MAP_H      (MAP_H),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_c),
    .adv        (adv_c),
    .issue_d    (rd_en_d),
    .elem_d     (elem_d),
    .last_win_c (last_win_c),
    .addr       (rd_addr)
  );

  // Next state; outputs are registered from the next-state view so they align with the state.
  always_comb begin
    state_d = state_q;
    elem_d  = '0;
    adv_c   = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.go) state_d = bus.pool_bsy ? WAIT : ISSUE;
      WAIT:  if (!bus.pool_bsy) state_d = ISSUE;
      ISSUE: begin
        if (elem_q == ELEM_W'(WIN_ELEMS - 1)) begin
          state_d = last_win_c ? DONE : GAP;
        end else begin
          elem_d = elem_q + ELEM_W'(1);
        end
      end
      GAP: begin
        adv_c   = 1'b1;
        state_d = bus.pool_bsy ? WAIT : ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      elem_d  = '0;
      adv_c   = 1'b0;
    end
    clr_c   = (state_q == IDLE) || (state_d == IDLE);
    win_d   = clr_c ? '0 : (adv_c ? win_q + WIN_W'(1) : win_q);
    rd_en_d = (state_d == ISSUE);
    strt_d  = rd_en_d && (elem_d == '0);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      win_q   <= '0;
      rd_en_q <= 1'b0;
      strt_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      win_q   <= win_d;
      rd_en_q <= rd_en_d;
      strt_q  <= strt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.src_rd_en   = rd_en_q;
  assign bus.src_rd_addr = rd_addr;
  assign bus.pool_strt   = strt_q;
  assign bus.win_cnt     = win_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pool_sched.sv
// Randomized scoreboard bench for pool_sched plus a directed 4x2 map instance.
module tb_pool_sched;

  localparam int unsigned MAP_W      = 8;
  localparam int unsigned MAP_H      = 8;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned NWIN       = MAP_W * MAP_H / 4;
  localparam int unsigned WIN_W      = $clog2(NWIN);
  localparam int unsigned S_W        = 4;
  localparam int unsigned S_H        = 2;
  localparam int unsigned S_AW       = 3;
  localparam int          NO_KILL    = 1 << 30;

  typedef struct {
    int cyc;
    int addr;
    bit strt;
    int win;
    bit done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_sched_if #(.ADDR_WIDTH(ADDR_WIDTH), .WIN_W(WIN_W)) bus ();
  pool_sched_if #(.ADDR_WIDTH(S_AW), .WIN_W(1)) sbus ();

  pool_sched #(.MAP_W(MAP_W), .MAP_H(MAP_H), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pool_sched #(.MAP_W(S_W), .MAP_H(S_H), .ADDR_WIDTH(S_AW)) sdut (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  // Element k of window w, straight from the row-pair/column-pair geometry.
  function automatic int exp_addr(input int w, input int k, input int mw);
    int r;
    int c;
    r = w / (mw / 2);
    c = w % (mw / 2);
    return 2 * r * mw + 2 * c + (k / 2) * mw + (k % 2);
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: pop one expectation for every read strobe or done pulse.
  always @(negedge clk) begin
    if (bus.src_rd_en || bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rd_en=%0d done=%0d addr=%0d at cycle %0d, expected nothing",
                 bus.src_rd_en, bus.done, bus.src_rd_addr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("item_cycle", cyc, mon_e.cyc);
        check("done_flag", int'(bus.done), int'(mon_e.done));
        if (!mon_e.done) begin
          check("rd_addr", int'(bus.src_rd_addr), mon_e.addr);
          check("pool_strt", int'(bus.pool_strt), int'(mon_e.strt));
          check("win_cnt", int'(bus.win_cnt), mon_e.win);
        end
      end
    end else begin
      check("idle_strt_addr", int'(bus.pool_strt) + int'(bus.src_rd_addr), 0);
    end
  end

  // One frame: pre-draw pool_bsy, derive the expected read timeline, then drive it.
  task automatic run_frame(input int unsigned stall_pct, input int kill_at,
                           input bit kill_rst, input bit extra_go);
    bit bq[$];
    int g;
    int d;
    int e;
    int start;
    int done_off;
    int end_off;
    g = cyc;
    d = 0;
    for (int w = 0; w < int'(NWIN); w++) begin
      e = d;
      while (bq.size() <= e) bq.push_back($urandom_range(0, 99) < stall_pct);
      while (bq[e]) begin
        e++;
        while (bq.size() <= e) bq.push_back($urandom_range(0, 99) < stall_pct);
      end
      start = e + 1;
      for (int k = 0; k < 4; k++) begin
        if (start + k <= kill_at)
          exp_q.push_back('{g + start + k, exp_addr(w, k, int'(MAP_W)), k == 0, w, 1'b0});
      end
      d = start + 4;
    end
    done_off = d;
    if (done_off <= kill_at) exp_q.push_back('{g + done_off, 0, 1'b0, 0, 1'b1});
    end_off = (kill_at < done_off) ? kill_at : done_off;
    while (bq.size() <= end_off) bq.push_back($urandom_range(0, 99) < stall_pct);
    for (int o = 0; o <= end_off; o++) begin
      if (o > 0) check("busy_in_frame", int'(bus.busy), 1);
      bus.go       = (o == 0) || (extra_go && ($urandom_range(0, 3) == 0));
      bus.pool_bsy = bq[o];
      bus.abort    = !kill_rst && (o == kill_at);
      rst          = kill_rst && (o == kill_at);
      @(posedge clk);
      #1;
    end
    bus.go       = 1'b0;
    bus.abort    = 1'b0;
    bus.pool_bsy = 1'($urandom_range(0, 1));
    check("busy_after", int'(bus.busy), 0);
    check("rd_en_after", int'(bus.src_rd_en), 0);
    check("done_after", int'(bus.done), 0);
    if (kill_at < done_off) check("win_cnt_after_kill", int'(bus.win_cnt), 0);
    check("scoreboard_drain", exp_q.size(), 0);
    rst = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 4x2 map: windows (0,1,4,5), (2,3,6,7); done on cycle 10.
  task automatic run_small();
    int w;
    int k;
    bit exp_rd;
    sbus.go = 1'b1;
    @(posedge clk);
    #1;
    sbus.go = 1'b0;
    for (int o = 1; o <= 11; o++) begin
      w      = (o - 1) / 5;
      k      = (o - 1) % 5;
      exp_rd = (o <= 10) && (k < 4);
      check("s_rd_en", int'(sbus.src_rd_en), int'(exp_rd));
      if (exp_rd) begin
        check("s_rd_addr", int'(sbus.src_rd_addr), exp_addr(w, k, int'(S_W)));
        check("s_pool_strt", int'(sbus.pool_strt), int'(k == 0));
      end
      check("s_done", int'(sbus.done), int'(o == 10));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.go        = 1'b0;
    bus.abort     = 1'b0;
    bus.pool_bsy  = 1'b0;
    sbus.go       = 1'b0;
    sbus.abort    = 1'b0;
    sbus.pool_bsy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", int'(bus.src_rd_en), 0);
    check("rst_rd_addr", int'(bus.src_rd_addr), 0);
    check("rst_pool_strt", int'(bus.pool_strt), 0);
    check("rst_win_cnt", int'(bus.win_cnt), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(0, NO_KILL, 1'b0, 1'b0);
    run_frame(0, 28, 1'b0, 1'b0);
    run_frame(0, NO_KILL, 1'b0, 1'b1);
    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(30, NO_KILL, 1'b0, 1'b1);
    run_frame(20, 37, 1'b1, 1'b1);
    repeat (6) begin
      run_frame($urandom_range(0, 50),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 120)) : NO_KILL,
                1'($urandom_range(0, 1)) & 1'($urandom_range(0, 1)), 1'b1);
    end
    run_small();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_sched.md
POOL_SCHED -- requirements
Module: pool_sched

Interface
REQ-001 SHALL have parameter MAP_W, default 8: feature-map width in elements; even, >=2.
REQ-002 SHALL have parameter MAP_H, default 8: feature-map height in elements; even, >=2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 7: source RAM address width; MAP_W*MAP_H <= 2**ADDR_WIDTH.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 go  input  1  start-frame pulse; honoured only in IDLE.
REQ-008 abort  input  1  synchronous frame abort.
REQ-009 pool_bsy  input  1  pooling unit cannot accept a new window.
REQ-010 src_rd_en  output  1  source RAM read strobe.
REQ-011 src_rd_addr  output  ADDR_WIDTH  source RAM read address.
REQ-012 pool_strt  output  1  one-cycle pulse marking the first element of a window.
REQ-013 win_cnt  output  $clog2(MAP_W*MAP_H/4)  index of the current window.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement the states IDLE, WAIT, ISSUE, GAP and DONE.
REQ-017 SHALL cover 2x2 non-overlapping windows, row-pair major then column-pair, for NWIN = MAP_W*MAP_H/4 windows.
REQ-018 Window base SHALL be (2r)*MAP_W + 2c, where r is the row pair and c is the column pair.
REQ-019 Element order SHALL be base, base+1, base+MAP_W, base+MAP_W+1.
REQ-020 Base SHALL update incrementally: +2 within a row pair; +MAP_W+2 at the end of a row pair; no multiplier.
REQ-021 IDLE: on go, SHALL go to ISSUE if pool_bsy=0, else to WAIT; base and win_cnt SHALL be cleared.
REQ-022 WAIT: SHALL hold while pool_bsy=1 and go to ISSUE on the first cycle pool_bsy=0.
REQ-023 ISSUE SHALL last exactly 4 cycles (element counter 0..3), with src_rd_en=1 and src_rd_addr per REQ-019.
REQ-024 pool_strt SHALL be high only on element 0; pool_bsy SHALL be ignored inside ISSUE.
REQ-025 After element 3 of a non-last window: SHALL enter GAP for 1 cycle, then advance the window and go to ISSUE or WAIT per pool_bsy.
REQ-026 After element 3 of the last window: SHALL enter DONE; done=1 for that cycle; then IDLE.
REQ-027 Unstalled cadence SHALL be 5 cycles per window; frame length from go SHALL be 5*NWIN cycles, with done in cycle 5*NWIN.
REQ-028 win_cnt SHALL increment when leaving GAP and SHALL NOT wrap within a frame.
REQ-029 go outside IDLE SHALL be ignored.
REQ-030 abort in any state SHALL force IDLE next cycle, clear counters and base, and suppress done.
REQ-031 abort and go together in IDLE: abort SHALL win and the state SHALL stay IDLE.
REQ-032 Outside ISSUE, src_rd_en=0, pool_strt=0 and src_rd_addr=0.

Reset
REQ-033 rst SHALL have priority over abort and go.
REQ-034 rst SHALL give state=IDLE, base=0, element counter=0, win_cnt=0.
REQ-035 All outputs SHALL be 0 during and after rst.
REQ-036 rst mid-frame SHALL abandon the frame without done.

Structure
REQ-037 Package pool_pkg SHALL hold the pool_sched_state_t enum (IDLE, WAIT, ISSUE, GAP, DONE) and the 2x2 window-size constant.
REQ-038 Sub-module pool_addr_gen SHALL contain base, column-pair and row-pair counters and element-offset addressing; pool_sched holds the FSM.

Verification
REQ-039 Defaults, go at cycle 0, pool_bsy=0 -> addresses 0,1,8,9 at cycles 1-4; pool_strt at 1; next window 2,3,10,11 at cycles 6-9; done at cycle 80 only.
REQ-040 Row-pair wrap -> window 3 = 6,7,14,15; window 4 = 16,17,24,25.
REQ-041 pool_bsy=1 for 3 cycles after window 0's GAP -> WAIT holds 3 cycles, then window 1 reads 2,3,10,11; win_cnt=1.
REQ-042 abort during window 5 element 2 -> IDLE next cycle, rd_en=0, no done, win_cnt=0; a new go restarts at address 0.
REQ-043 go while busy, and go+abort in IDLE -> no effect; busy stays correct.
REQ-044 MAP_W=4, MAP_H=2 -> 2 windows (0,1,4,5), (2,3,6,7); done at cycle 10.
